// File: rtl/program_sequencer_pkg.sv
// Shared types and default widths for the program sequencer.
package program_sequencer_pkg;

    // Default geometry: 2048 x 16 program memory, 5-bit opcode in the top bits.
    localparam int unsigned DEF_ADDR_W   = 11;
    localparam int unsigned DEF_DATA_W   = 16;
    localparam int unsigned DEF_OPCODE_W = 5;

    // Opcode that stops sequencing; the halt word itself is never issued.
    localparam logic [DEF_OPCODE_W-1:0] HALT_OPCODE_DEF = 5'b00000;

    // Sequencer control states.
    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StFetch  = 2'b01,
        StIssue  = 2'b10,
        StHalted = 2'b11
    } seq_state_e;

endpackage

// File: rtl/pc_register.sv
// Program counter: async reset, parallel load, increment with natural wrap.
module pc_register #(
    parameter int unsigned ADDR_W   = 11,
    parameter int unsigned RESET_PC = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_value,
    input  logic              incr,
    output logic [ADDR_W-1:0] pc
);

    localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_PC);

    // Load wins over increment; increment wraps modulo 2^ADDR_W.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_VAL;
        end else if (load) begin
            pc <= load_value;
        end else if (incr) begin
            pc <= pc + 1'b1;
        end
    end

endmodule

// File: rtl/program_sequencer.sv
// Fetch controller: owns the PC, latches instruction words from program
// memory and offers them to the datapath over a valid/ready handshake.
module program_sequencer
    import program_sequencer_pkg::*;
#(
    parameter int unsigned         ADDR_W      = DEF_ADDR_W,
    parameter int unsigned         DATA_W      = DEF_DATA_W,
    parameter int unsigned         OPCODE_W    = DEF_OPCODE_W,
    parameter logic [OPCODE_W-1:0] HALT_OPCODE = HALT_OPCODE_DEF,
    parameter int unsigned         RESET_PC    = 0,
    parameter int unsigned         CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] pm_addr,
    input  logic [DATA_W-1:0] pm_data,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target,
    output logic              halted,
    output logic [CNT_W-1:0]  retired
);

    localparam logic [ADDR_W-1:0] RESET_VAL = ADDR_W'(RESET_PC);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    seq_state_e state;

    logic              start_ok;
    logic              accept;
    logic              is_halt;
    logic              pc_load;
    logic              pc_incr;
    logic [ADDR_W-1:0] pc_load_value;

    // Decode handshake and control events from the current state.
    always_comb begin
        start_ok      = start && ((state == StIdle) || (state == StHalted));
        accept        = (state == StIssue) && instr_ready;
        is_halt       = (pm_data[DATA_W-1 -: OPCODE_W] == HALT_OPCODE);
        pc_load       = start_ok || (accept && jump_en);
        pc_incr       = accept && !jump_en;
        pc_load_value = start_ok ? RESET_VAL : jump_target;
    end

    pc_register #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk        (clk),
        .reset      (reset),
        .load       (pc_load),
        .load_value (pc_load_value),
        .incr       (pc_incr),
        .pc         (pm_addr)
    );

    // Sequencer FSM with registered instruction, valid, halted and retire count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= StIdle;
            instr       <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            retired     <= '0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        retired <= '0;
                        state   <= StFetch;
                    end
                end
                StFetch: begin
                    instr <= pm_data;
                    if (is_halt) begin
                        halted <= 1'b1;
                        state  <= StHalted;
                    end else begin
                        instr_valid <= 1'b1;
                        state       <= StIssue;
                    end
                end
                StIssue: begin
                    if (instr_ready) begin
                        instr_valid <= 1'b0;
                        state       <= StFetch;
                        if (retired != CNT_MAX) begin
                            retired <= retired + 1'b1;
                        end
                    end
                end
                StHalted: begin
                    if (start) begin
                        halted  <= 1'b0;
                        retired <= '0;
                        state   <= StFetch;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
